cache_port_arbiter: RTL
=======================

# cache_port_arbiter

Two-requester front end for the `cache` block: it shares the single cache port between an instruction-fetch requester (port 0, read-only) and a data requester (port 1, read/write). It runs the cache `ren`/`wen`/`cache_rdy` handshake on behalf of the winning requester and returns read data with a one-cycle completion pulse. It also keeps per-port grant counters and flags requests the cache never accepts. It sits between the core's fetch/LSU logic and `cache`; `cache` and its SRAM cells and main memory are unchanged.

## Interface
- `ISSUE_TIMEOUT`, 16: cycles allowed in ISSUE for `cache_rdy` to fall before the request is aborted with error.
- `CNT_W`, 16: width of the per-port grant counters.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `if_req` in 1: fetch request; held until `if_gnt`.
- `if_addr` in 32: fetch address.
- `if_gnt` out 1: one-cycle pulse; the request is accepted and its payload latched.
- `if_done` out 1: one-cycle pulse; `if_rdata`/`if_err` are valid.
- `if_rdata` out 32: fetch data.
- `if_err` out 1: timeout flag, qualified by `if_done`.
- `d_req`, `d_we` in 1 each: data request; 1 = store.
- `d_addr`, `d_wdata` in 32 each: data address and store data.
- `d_loadcntrl` in 5: load control, passed through.
- `d_storecntrl` in 3: store control, passed through.
- `d_gnt`, `d_done`, `d_err` out 1 each: same rules as the fetch port.
- `d_rdata` out 32: load data.
- `cache_ren`, `cache_wen` out 1 each: to `cache` `ren`/`wen`.
- `cache_addr`, `cache_din` out 32 each: to `cache`.
- `cache_loadcntrl` out 5, `cache_storecntrl` out 3: to `cache`.
- `cache_dout` in 32: from `cache`.
- `cache_rdy` in 1: from `cache`.
- `if_grants`, `d_grants` out CNT_W: grant counters; wrap modulo 2^CNT_W.

## Operation
- States: IDLE, ISSUE, WAIT.
- **IDLE**: if `cache_rdy`=1 and any request is pending, pick a winner.
  - Only one request pending: that port wins.
  - Both pending: round-robin. `last` holds the most recent winner; the other port wins. Reset value of `last` is port 0, so the data port wins the first tie.
  - At the clock edge: latch the winner's payload. Fetch always uses loadcntrl 5'b00100 (LOAD_WORD), storecntrl 0, `wen`=0.
  - Set that port's `gnt` for one cycle, increment its counter, clear the timeout counter, go to ISSUE.
- **ISSUE**: drive `cache_ren` = !we and `cache_wen` = we, with the latched payload.
  - When `cache_rdy`=0 is sampled: deassert `ren`/`wen` and the control fields (cleared to 0), go to WAIT.
  - If the timeout counter reaches ISSUE_TIMEOUT-1 first: pulse `done`+`err` on the owner port, drop `ren`/`wen`, go to IDLE.
- **WAIT**: all cache strobes are 0.
  - When `cache_rdy`=1 is sampled: register `cache_dout` into the owner's `rdata`, pulse the owner's `done` (err=0), go to IDLE.
- A store also pulses `done`. Its `rdata` is updated with `cache_dout`, and the value is don't-care.
- `cache_addr`/`cache_din` hold their last value outside ISSUE.
- A requester keeps `req` high across `gnt` only if it has a further request. A request held high after `gnt` is treated as a new request once the FSM is back in IDLE.
- Reset values: state IDLE, `last`=0, all `gnt`/`done`/`err`/`ren`/`wen` 0, `rdata` 0, counters 0, cache addr/din/cntrl 0.
- Reset mid-transaction: the transaction is dropped and no `done` is issued. `cache` shares `rst`, so no partial handshake survives.

## Timing
- All outputs are registered.
- Grant: `req` sampled at edge N; `gnt` and `cache_ren`/`cache_wen` are high during cycle N+1.
- Issue duration: `ren`/`wen` stay high from N+1 through the cycle in which `cache_rdy` is first sampled low, inclusive.
- Completion: `done` is high during the cycle after the edge that samples `cache_rdy`=1 in WAIT.
- Back-to-back: the next grant edge is at the earliest the edge after `done` rises, because the FSM is in IDLE during the `done` cycle.
- IDLE with `cache_rdy`=0 (e.g. cache still busy after reset): no grant is issued; requests wait.
- Timeout counter width is $clog2(ISSUE_TIMEOUT); it saturates and is only used in ISSUE.

## Structure
- Package `cache_arb_pkg`:
  - `arb_state_t` enum {IDLE, ISSUE, WAIT}.
  - `port_t` (0 = IF, 1 = DATA).
  - LOAD_WORD = 5'b00100, STORE_WORD = 3'b100.
  - Request payload struct: we, addr, wdata, loadcntrl, storecntrl.
- Sub-module `cache_arb_rr`: 2-way round-robin pick from (req0, req1, last), returning the winner and a valid bit. Purely combinational; `last` is held in the parent.

## Test plan
- Fetch alone: `if_req` addr 0x0; behavioural cache with a miss.
  - `if_gnt` 1 cycle after the request; `cache_ren` drops after `cache_rdy` falls.
  - `if_done` with `if_rdata` = memory word at 0x0; `if_grants`=1.
- Data store then load: store 0x00001000 = 0xdeadbeef (`d_storecntrl` 3'b100), then load 0x00001000.
  - Two `d_done` pulses; the second returns `d_rdata` = 0xdeadbeef; `cache_wen` is never high in the load.
- Simultaneous requests: fetch 0x4, data 0x8, both held continuously after reset.
  - Grants go DATA, IF, DATA, IF; no overlap of `gnt`.
  - `done` count per port equals `gnt` count.
- Timeout: `cache_rdy` forced to 1 and ignoring `ren`.
  - After 16 ISSUE cycles, `if_done`=1 and `if_err`=1; FSM in IDLE; `cache_ren`=0.
- Reset mid-WAIT: assert `rst` while `cache_rdy`=0.
  - All outputs are 0 immediately (async); no `done` afterwards; counters are 0.
- Counter wrap with CNT_W=4: 17 fetch grants → `if_grants`=1.

Source files
------------

// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the two-port cache front-end arbiter.
package cache_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_IF   = 1'b0,
    PORT_DATA = 1'b1
  } port_t;

  localparam logic [4:0] LOAD_WORD  = 5'b00100;
  localparam logic [2:0] STORE_WORD = 3'b100;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  loadcntrl;
    logic [2:0]  storecntrl;
  } req_t;

endpackage

// File: rtl/cache_arb_rr.sv
// Two-way round-robin pick: on a tie the port that did not win last time goes next.
module cache_arb_rr
  import cache_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic win,
  output logic vld
);

  always_comb begin
    vld = req0 | req1;
    if (req0 && req1)
      win = (last == logic'(PORT_IF)) ? logic'(PORT_DATA) : logic'(PORT_IF);
    else if (req1)
      win = logic'(PORT_DATA);
    else
      win = logic'(PORT_IF);
  end

endmodule

// File: rtl/cache_port_arbiter.sv
// Shares the single cache port between the fetch and data requesters and runs the
// ren/wen/cache_rdy handshake for the winner; all outputs are registered.
module cache_port_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ISSUE_TIMEOUT = 16,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [31:0]      if_addr,
  output logic             if_gnt,
  output logic             if_done,
  output logic [31:0]      if_rdata,
  output logic             if_err,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [31:0]      d_addr,
  input  logic [31:0]      d_wdata,
  input  logic [4:0]       d_loadcntrl,
  input  logic [2:0]       d_storecntrl,
  output logic             d_gnt,
  output logic             d_done,
  output logic             d_err,
  output logic [31:0]      d_rdata,
  output logic             cache_ren,
  output logic             cache_wen,
  output logic [31:0]      cache_addr,
  output logic [31:0]      cache_din,
  output logic [4:0]       cache_loadcntrl,
  output logic [2:0]       cache_storecntrl,
  input  logic [31:0]      cache_dout,
  input  logic             cache_rdy,
  output logic [CNT_W-1:0] if_grants,
  output logic [CNT_W-1:0] d_grants
);

  localparam int TMO_W = (ISSUE_TIMEOUT > 1) ? $clog2(ISSUE_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ISSUE_TIMEOUT - 1);

  arb_state_t       state;
  port_t            last;
  port_t            owner;
  port_t            win;
  logic             win_raw;
  logic             win_vld;
  logic [TMO_W-1:0] tmo_cnt;
  req_t             if_pl;
  req_t             d_pl;
  req_t             win_pl;

  cache_arb_rr u_rr (
    .req0 (if_req),
    .req1 (d_req),
    .last (logic'(last)),
    .win  (win_raw),
    .vld  (win_vld)
  );

  // Fetch is always a plain word load; the data port passes its controls straight through.
  always_comb begin
    win    = port_t'(win_raw);
    if_pl  = '{we: 1'b0, addr: if_addr, wdata: 32'h0,
               loadcntrl: LOAD_WORD, storecntrl: 3'b000};
    d_pl   = '{we: d_we, addr: d_addr, wdata: d_wdata,
               loadcntrl: d_loadcntrl, storecntrl: d_storecntrl};
    win_pl = (win == PORT_DATA) ? d_pl : if_pl;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      last             <= PORT_IF;
      owner            <= PORT_IF;
      tmo_cnt          <= '0;
      if_gnt           <= 1'b0;
      if_done          <= 1'b0;
      if_err           <= 1'b0;
      if_rdata         <= 32'h0;
      d_gnt            <= 1'b0;
      d_done           <= 1'b0;
      d_err            <= 1'b0;
      d_rdata          <= 32'h0;
      cache_ren        <= 1'b0;
      cache_wen        <= 1'b0;
      cache_addr       <= 32'h0;
      cache_din        <= 32'h0;
      cache_loadcntrl  <= 5'h0;
      cache_storecntrl <= 3'h0;
      if_grants        <= '0;
      d_grants         <= '0;
    end else begin
      if_gnt  <= 1'b0;
      d_gnt   <= 1'b0;
      if_done <= 1'b0;
      d_done  <= 1'b0;
      if_err  <= 1'b0;
      d_err   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cache_rdy && win_vld) begin
            owner            <= win;
            last             <= win;
            tmo_cnt          <= '0;
            cache_ren        <= ~win_pl.we;
            cache_wen        <= win_pl.we;
            cache_addr       <= win_pl.addr;
            cache_din        <= win_pl.wdata;
            cache_loadcntrl  <= win_pl.loadcntrl;
            cache_storecntrl <= win_pl.storecntrl;
            if (win == PORT_DATA) begin
              d_gnt    <= 1'b1;
              d_grants <= d_grants + CNT_W'(1);
            end else begin
              if_gnt    <= 1'b1;
              if_grants <= if_grants + CNT_W'(1);
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          // The cache acknowledges by dropping rdy; a request it never takes is aborted.
          if (!cache_rdy) begin
            cache_ren        <= 1'b0;
            cache_wen        <= 1'b0;
            cache_loadcntrl  <= 5'h0;
            cache_storecntrl <= 3'h0;
            state            <= WAIT;
          end else if (tmo_cnt == TMO_LAST) begin
            cache_ren        <= 1'b0;
            cache_wen        <= 1'b0;
            cache_loadcntrl  <= 5'h0;
            cache_storecntrl <= 3'h0;
            if (owner == PORT_DATA) begin
              d_done <= 1'b1;
              d_err  <= 1'b1;
            end else begin
              if_done <= 1'b1;
              if_err  <= 1'b1;
            end
            state <= IDLE;
          end else if (tmo_cnt != '1) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        WAIT: begin
          if (cache_rdy) begin
            if (owner == PORT_DATA) begin
              d_rdata <= cache_dout;
              d_done  <= 1'b1;
            end else begin
              if_rdata <= cache_dout;
              if_done  <= 1'b1;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
